// File: rtl/ccff_bitstream_loader.sv
// Purpose : feeds the CLB configuration chain, serialising valid/ready bitstream words MSB-first
//           onto ccff_head with a per-bit shift enable, stopping after exactly CHAIN_LEN bits.
// Latency : 1 FETCH bubble per word, then WORD_W shift cycles (WORD_W bits per WORD_W+1 cycles).
// Backpr. : bs_ready is high only in FETCH; an underrun stalls in FETCH with shift enable low.
//
// Ports:
//   prog_clk, prog_reset          clock and synchronous active-high reset
//   start, abort                  load control (abort wins over start)
//   bs_data/bs_valid/bs_ready     bitstream word stream
//   ccff_head, ccff_shift_en      registered serial bit and chain clock-gate enable
//   ccff_tail                     bit emerging from the far end of the chain
//   busy, done, bit_cnt           status; done is sticky until start/abort/reset
// Optional feature macro CCFF_READBACK_CRC_EN adds readback_crc[15:0], a CRC-16-CCITT
// signature of ccff_tail over every shifting cycle of the current load.

module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 88,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt
`ifdef CCFF_READBACK_CRC_EN
    ,
    output logic [15:0]       readback_crc
`endif
);

    localparam int REM_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                head_q, head_d;
    logic                sen_q, sen_d;
    logic                load_start;
    logic [31:0]         left_w;
    logic [REM_W-1:0]    fill;

    // Bits still owed to the chain; the last word may be only partly used.
    always_comb begin
        left_w = 32'(CHAIN_LEN) - 32'(cnt_q);
        fill   = (left_w > 32'(WORD_W)) ? REM_W'(WORD_W) : REM_W'(left_w);
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        load_start = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    load_start = 1'b1;
                end
            end
            S_FETCH: begin
                if (bs_valid) begin
                    sreg_d  = bs_data;
                    rem_d   = fill;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                rem_d  = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d = (cnt_q == CNT_W'(CHAIN_LEN - 1)) ? S_DONE : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d    = S_IDLE;
            sreg_d     = sreg_q;
            rem_d      = rem_q;
            cnt_d      = cnt_q;
            load_start = 1'b0;
        end
    end

    // Head and enable are registered from next-state so they stay cycle-aligned;
    // outside SHIFT the head simply holds its last driven bit.
    always_comb begin
        sen_d  = (state_d == S_SHIFT);
        head_d = (state_d == S_SHIFT) ? sreg_d[WORD_W-1] : head_q;
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            sen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            sen_q   <= sen_d;
        end
    end

    assign bs_ready      = (state_q == S_FETCH);
    assign busy          = (state_q == S_FETCH) || (state_q == S_SHIFT);
    assign done          = (state_q == S_DONE);
    assign bit_cnt       = cnt_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = sen_q;

`ifdef CCFF_READBACK_CRC_EN
    // The tail bit is valid in the same cycle the chain shifts, so sample it on sen_q.
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;

    always_comb begin
        crc_fb = crc_q[15] ^ ccff_tail;
        crc_d  = crc_q;
        if (load_start) begin
            crc_d = 16'hFFFF;
        end else if (sen_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign readback_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule
